// File: rtl/m_shift_pipe.sv
// Stallable register-per-stage delay line with per-stage valid bits,
// a selectable tap read port, synchronous flush and occupancy count.
module m_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int SELW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_en,
    input  logic             w_flush,
    input  logic             w_vin,
    input  logic [WIDTH-1:0] w_din,
    input  logic [SELW-1:0]  w_sel,
    output logic [WIDTH-1:0] w_dout,
    output logic             w_vout,
    output logic [WIDTH-1:0] w_tap,
    output logic             w_vtap,
    output logic [CNTW-1:0]  w_cnt
);

    logic [WIDTH-1:0] data_reg   [DEPTH];
    logic             valid_reg  [DEPTH];
    logic [WIDTH-1:0] data_prev  [DEPTH];
    logic             valid_prev [DEPTH];
    logic [CNTW-1:0]  cnt_reg;
    logic [CNTW-1:0]  cnt_next;

    // Each stage loads what its predecessor held before the edge; stage 0 loads the input.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign data_prev[gi]  = w_din;
                assign valid_prev[gi] = w_vin;
            end else begin : g_body
                assign data_prev[gi]  = data_reg[gi-1];
                assign valid_prev[gi] = valid_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_reg[k]  <= '0;
                valid_reg[k] <= 1'b0;
            end
        end else if (w_flush) begin
            // Flush only invalidates; data registers keep their contents.
            for (int k = 0; k < DEPTH; k++) begin
                valid_reg[k] <= 1'b0;
            end
        end else if (w_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_reg[k]  <= data_prev[k];
                valid_reg[k] <= valid_prev[k];
            end
        end
    end

    // Incremental count: the modular arithmetic cannot leave 0..DEPTH because
    // an increment at full occupancy always coincides with a valid leaving.
    always_comb begin
        cnt_next = cnt_reg;
        if (w_flush) begin
            cnt_next = '0;
        end else if (w_en) begin
            cnt_next = cnt_reg + CNTW'(w_vin) - CNTW'(valid_reg[DEPTH-1]);
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Out-of-range selects fall through every comparison and read as zero.
    always_comb begin
        w_tap  = '0;
        w_vtap = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_sel == SELW'(k)) begin
                w_tap  = data_reg[k];
                w_vtap = valid_reg[k];
            end
        end
    end

    assign w_dout = data_reg[DEPTH-1];
    assign w_vout = valid_reg[DEPTH-1];
    assign w_cnt  = cnt_reg;

endmodule
